// File: rtl/lfsr_seq_pkg.sv
// Shared types and constants for the LFSR sequencer.
// Optional build macro: LFSR_ZERO_GUARD_EN. When defined, an all-zero seed is replaced
// by GUARD_SEED so the register cannot lock up at zero.
package lfsr_seq_pkg;

    // Controller states
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StClear = 3'd1,
        StLoad  = 3'd2,
        StRun   = 3'd3,
        StDone  = 3'd4
    } state_e;

    // Shift register mode codes
    localparam logic [1:0] SH_CLR  = 2'b00;
    localparam logic [1:0] SH_LOAD = 2'b01;
    localparam logic [1:0] SH_STEP = 2'b10;
    localparam logic [1:0] SH_HOLD = 2'b11;

    localparam logic [7:0] GUARD_SEED = 8'h01;

    // Seed actually loaded into the register
    function automatic logic [7:0] effective_seed(input logic [7:0] seed);
`ifdef LFSR_ZERO_GUARD_EN
        return (seed == 8'h00) ? GUARD_SEED : seed;
`else
        return seed;
`endif
    endfunction

endpackage

// File: rtl/lfsr_seq_ctrl_if.sv
// Request/response handshake bundle between a requester and the LFSR sequencer.
interface lfsr_seq_ctrl_if #(
    parameter int unsigned CNT_W = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [7:0]       req_seed;
    logic [CNT_W-1:0] req_count;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [7:0]       rsp_data;

    // Requester / result consumer side
    modport master (
        output req_valid,
        output req_seed,
        output req_count,
        output rsp_ready,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data
    );

    // Sequencer side
    modport slave (
        input  req_valid,
        input  req_seed,
        input  req_count,
        input  rsp_ready,
        output req_ready,
        output rsp_valid,
        output rsp_data
    );
endinterface

// File: rtl/lfsr_step_cnt.sv
// Step counter: loads a count, decrements on request, never wraps below zero.
module lfsr_step_cnt #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             is_zero_o,
    output logic             is_one_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next count: load has priority, decrement saturates at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign is_zero_o = (cnt_q == '0);
    assign is_one_o  = (cnt_q == CNT_W'(1));
endmodule

// File: rtl/lfsr_seq_ctrl.sv
// LFSR sequencer: takes a seed/count request, drives the external shift register through
// clear, load and count steps, then presents the register value as a response.
// Optional build macro: LFSR_ZERO_GUARD_EN (see lfsr_seq_pkg).
module lfsr_seq_ctrl #(
    parameter int unsigned CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    lfsr_seq_ctrl_if.slave bus,
    output logic       busy,
    output logic [1:0] sr_shamt,
    output logic [7:0] sr_din,
    input  logic [7:0] sr_data
);
    import lfsr_seq_pkg::*;

    state_e     state_q, state_d;
    logic [1:0] shamt_q, shamt_d;
    logic [7:0] din_q, din_d;

    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_zero;
    logic             cnt_one;

    lfsr_step_cnt #(
        .CNT_W (CNT_W)
    ) u_step_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (bus.req_count),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt_val),
        .is_zero_o  (cnt_zero),
        .is_one_o   (cnt_one)
    );

    // Next-state and registered shift-register controls
    always_comb begin
        state_d  = state_q;
        shamt_d  = shamt_q;
        din_d    = din_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Reset leaves shamt at clear; idle holds once the clock runs
                shamt_d = SH_HOLD;
                if (bus.req_valid) begin
                    cnt_load = 1'b1;
                    din_d    = effective_seed(bus.req_seed);
                    shamt_d  = SH_CLR;
                    state_d  = StClear;
                end
            end
            StClear: begin
                shamt_d = SH_LOAD;
                state_d = StLoad;
            end
            StLoad: begin
                if (cnt_zero) begin
                    shamt_d = SH_HOLD;
                    state_d = StDone;
                end else begin
                    shamt_d = SH_STEP;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Register steps on every edge here; the last step is the one seen at count 1
                cnt_dec = 1'b1;
                if (cnt_one) begin
                    shamt_d = SH_HOLD;
                    state_d = StDone;
                end
            end
            StDone: begin
                shamt_d = SH_HOLD;
                if (bus.rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                shamt_d = SH_HOLD;
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            shamt_q <= SH_CLR;
            din_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            shamt_q <= shamt_d;
            din_q   <= din_d;
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign bus.rsp_valid = (state_q == StDone);
    assign bus.rsp_data  = sr_data;
    assign busy          = (state_q != StIdle);
    assign sr_shamt      = shamt_q;
    assign sr_din        = din_q;

    // Count value is only consumed through the zero/one flags
    logic unused_cnt;
    assign unused_cnt = ^cnt_val;
endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Scoreboard bench for lfsr_seq_ctrl with a behavioural 8-bit LFSR shift register.
module tb_lfsr_seq_ctrl;
    logic       clk;
    logic       rst_n;
    logic       busy;
    logic [1:0] sr_shamt;
    logic [7:0] sr_din;
    logic [7:0] sr_data;

    lfsr_seq_ctrl_if #(.CNT_W(8)) bus ();

    lfsr_seq_ctrl #(
        .CNT_W (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .sr_shamt (sr_shamt),
        .sr_din   (sr_din),
        .sr_data  (sr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External shift register: 00 clear, 01 load, 10 step, 11 hold
    always @(posedge clk) begin
        case (sr_shamt)
            2'b00:   sr_data <= 8'h00;
            2'b01:   sr_data <= sr_din;
            2'b10:   sr_data <= {sr_data[0] ^ sr_data[2] ^ sr_data[3] ^ sr_data[4], sr_data[7:1]};
            default: sr_data <= sr_data;
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    function automatic void fail_now(input string name);
        n_chk++;
        $display("FAIL %s: got timeout/unexpected expected in-bound event", name);
    endfunction

    typedef struct {
        logic [7:0] data;
        int         lat;
        int         acc;
    } exp_t;
    exp_t sb[$];

    // Monitor: checks each new response against the scoreboard, then its stability
    logic       prev_v = 1'b0;
    logic [7:0] held   = 8'h00;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (bus.rsp_valid && !prev_v) begin
                if (sb.size() == 0) begin
                    fail_now("unexpected_rsp");
                end else begin
                    e = sb.pop_front();
                    chk("rsp_data", {24'h0, bus.rsp_data}, {24'h0, e.data});
                    chk("rsp_latency", cyc - e.acc, e.lat);
                end
                held = bus.rsp_data;
            end else if (bus.rsp_valid) begin
                chk("rsp_stable", {24'h0, bus.rsp_data}, {24'h0, held});
            end
            prev_v = bus.rsp_valid;
        end
    end

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (bus.req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) fail_now("req_ready_timeout");
    endtask

    task automatic wait_drain();
        bit ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("drain_timeout");
    endtask

    // Issue one request; returns at the falling edge after the accepting edge
    task automatic send(input logic [7:0] seed, input logic [7:0] cnt,
                        input logic [7:0] exp, input bit drain);
        exp_t e;
        wait_ready();
        bus.req_valid = 1'b1;
        bus.req_seed  = seed;
        bus.req_count = cnt;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_seed  = ~seed;
        bus.req_count = cnt + 8'd7;
        e.data = exp;
        e.lat  = int'(cnt) + 2;
        e.acc  = cyc;
        sb.push_back(e);
        if (drain) wait_drain();
    endtask

    initial begin
        logic [7:0] zero_exp;
        bit         seen;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_seed  = 8'h00;
        bus.req_count = 8'h00;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        chk("rst_shamt", {30'h0, sr_shamt}, 32'h0);
        chk("rst_din", {24'h0, sr_din}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_shamt_hold", {30'h0, sr_shamt}, 32'h3);
        chk("idle_req_ready", {31'h0, bus.req_ready}, 32'h1);

        send(8'h01, 8'd1, 8'h80, 1'b1);
        send(8'h01, 8'd2, 8'h40, 1'b1);
        send(8'hFF, 8'd1, 8'h7F, 1'b1);
        send(8'h1D, 8'd1, 8'h0E, 1'b1);

        // Count 0: clear, load, hold
        send(8'hA5, 8'd0, 8'hA5, 1'b0);
        chk("a5_shamt_clr", {30'h0, sr_shamt}, 32'h0);
        chk("a5_din", {24'h0, sr_din}, 32'hA5);
        chk("a5_busy", {31'h0, busy}, 32'h1);
        @(negedge clk);
        chk("a5_shamt_load", {30'h0, sr_shamt}, 32'h1);
        @(negedge clk);
        chk("a5_shamt_hold", {30'h0, sr_shamt}, 32'h3);
        wait_drain();

`ifdef LFSR_ZERO_GUARD_EN
        zero_exp = 8'h20;
`else
        zero_exp = 8'h00;
`endif
        send(8'h00, 8'd3, zero_exp, 1'b1);

        // Back-pressure with an ignored second request
        bus.rsp_ready = 1'b0;
        send(8'h01, 8'd2, 8'h40, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (bus.rsp_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) fail_now("bp_rsp_timeout");
        bus.req_valid = 1'b1;
        bus.req_seed  = 8'h33;
        bus.req_count = 8'd5;
        repeat (10) begin
            @(negedge clk);
            chk("bp_rsp_valid", {31'h0, bus.rsp_valid}, 32'h1);
            chk("bp_rsp_data", {24'h0, bus.rsp_data}, 32'h40);
            chk("bp_req_ready", {31'h0, bus.req_ready}, 32'h0);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        wait_drain();
        repeat (5) @(negedge clk);
        chk("bp_ignored_busy", {31'h0, busy}, 32'h0);
        chk("bp_ignored_data", {24'h0, sr_data}, 32'h40);

        // Reset in the middle of a long run
        send(8'h01, 8'd100, 8'h00, 1'b0);
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
        chk("abort_shamt", {30'h0, sr_shamt}, 32'h0);
        sb.delete();
        repeat (2) @(negedge clk);
        chk("abort_reg_cleared", {24'h0, sr_data}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        send(8'h01, 8'd1, 8'h80, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "global timeout");
    end
endmodule
